// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter sharing one read-first BRAM port between two requesters
module bram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter logic [31:0] MEM_BYTES = 32'h00008000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        we0,
  input  logic [3:0]        we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              err0,
  output logic              err1,
  output logic [3:0]        web,
  output logic [ADDR_W-1:0] addrb,
  output logic [31:0]       dib,
  input  logic [31:0]       dob,
  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1
);
  logic lg_q, lg_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_idx_q, rsp_idx_d;
  logic rsp_err_q, rsp_err_d;
  logic [15:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;
  logic any, sel, in_range;
  logic [ADDR_W-1:0] addr_sel;
  always_comb begin
    gnt0 = !rst && req0 && (!req1 || lg_q);
    gnt1 = !rst && req1 && (!req0 || !lg_q);
    any = gnt0 || gnt1;
    sel = gnt1;
    addr_sel = sel ? addr1 : addr0;
    in_range = {32'd0, addr_sel} < {{ADDR_W{1'b0}}, MEM_BYTES};
    addrb = any ? addr_sel : '0;
    dib = any ? (sel ? wdata1 : wdata0) : 32'd0;
    web = (any && in_range) ? (sel ? we1 : we0) : 4'b0000;
    lg_d = any ? sel : lg_q;
    rsp_valid_d = any;
    rsp_idx_d = sel;
    rsp_err_d = !in_range;
    gcnt0_d = (gnt0 && gcnt0_q != 16'hFFFF) ? gcnt0_q + 16'd1 : gcnt0_q;
    gcnt1_d = (gnt1 && gcnt1_q != 16'hFFFF) ? gcnt1_q + 16'd1 : gcnt1_q;
    gcnt0 = gcnt0_q;
    gcnt1 = gcnt1_q;
    rvalid0 = !rst && rsp_valid_q && !rsp_idx_q;
    rvalid1 = !rst && rsp_valid_q && rsp_idx_q;
    err0 = rvalid0 && rsp_err_q;
    err1 = rvalid1 && rsp_err_q;
    rdata0 = (rvalid0 && !rsp_err_q) ? dob : 32'd0;
    rdata1 = (rvalid1 && !rsp_err_q) ? dob : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lg_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_idx_q <= 1'b0;
      rsp_err_q <= 1'b0;
      gcnt0_q <= 16'd0;
      gcnt1_q <= 16'd0;
    end else begin
      lg_q <= lg_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_err_q <= rsp_err_d;
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and randomized checks against a behavioural arbiter/memory model
module tb_bram_port_arbiter;
  localparam logic [31:0] MEMB = 32'h00008000;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [3:0] we0 = '0, we1 = '0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1, dib, dob;
  logic [3:0] web;
  logic [15:0] addrb, gcnt0, gcnt1;
  int n_checks = 0, n_pass = 0;
  logic [31:0] bram [16384];
  bit bram_ready;
  bit m_lg = 1'b1;
  int m_cnt [2] = '{0, 0};
  logic [31:0] m_mem [16384];
  bit m_rv = 1'b0, m_re = 1'b0;
  int m_ri = 0;
  logic [31:0] m_rd = '0;

  bram_port_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .web(web), .addrb(addrb), .dib(dib), .dob(dob), .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < 16384; i++) bram[i] <= i;
    end else begin
      dob <= bram[addrb[15:2]];
      for (int b = 0; b < 4; b++) if (web[b]) bram[addrb[15:2]][8*b+:8] <= dib[8*b+:8];
    end
    bram_ready <= 1'b1;
  end

  function automatic int winner();
    if (rst) return -1;
    if (req0 && req1) return m_lg ? 0 : 1;
    return req0 ? 0 : (req1 ? 1 : -1);
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 2))
      0: return 16'($urandom_range(0, 63));
      1: return 16'($urandom_range(32'h7FF0, 32'h800F));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick();
    int w, wi;
    logic [15:0] a;
    logic [3:0] we;
    logic [31:0] wd;
    w = winner();
    @(posedge clk);
    if (rst) begin
      m_lg = 1'b1;
      m_cnt = '{0, 0};
      m_rv = 1'b0;
    end else begin
      m_rv = (w >= 0);
      m_ri = w;
      if (w >= 0) begin
        a = (w == 1) ? addr1 : addr0;
        we = (w == 1) ? we1 : we0;
        wd = (w == 1) ? wdata1 : wdata0;
        wi = int'(a) / 4;
        m_lg = (w == 1);
        m_cnt[w] = (m_cnt[w] == 65535) ? 65535 : m_cnt[w] + 1;
        m_re = (32'(a) >= MEMB);
        m_rd = m_re ? 32'd0 : m_mem[wi];
        if (!m_re) for (int b = 0; b < 4; b++) if (we[b]) m_mem[wi][8*b+:8] = wd[8*b+:8];
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 4'hF; addr0 = 16'h0004; wdata0 = 32'h1234_5678;
    #1;
    n_checks++;
    if ({gnt0, gnt1, web, addrb, dib} !== 54'd0) $display("FAIL reset_port: got %h expected 0", {gnt0, gnt1, web, addrb, dib});
    else n_pass++;
    tick(); tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 4'h0;
    #1;
    n_checks++;
    if ({rvalid0, rvalid1, err0, err1, rdata0, rdata1, gcnt0, gcnt1} !== 100'd0)
      $display("FAIL reset_state: rv=%b%b err=%b%b gcnt=%h/%h expected all 0", rvalid0, rvalid1, err0, err1, gcnt0, gcnt1);
    else n_pass++;
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 4'h0; addr0 = 16'h0010;
    #1;
    n_checks++;
    if ({gnt0, gnt1, web, addrb} !== {2'b10, 4'h0, 16'h0010}) $display("FAIL read_grant: gnt=%b%b addrb=%h expected 10/0010", gnt0, gnt1, addrb);
    else n_pass++;
    tick();
    req0 = 1'b0;
    #1;
    n_checks++;
    if ({rvalid0, err0, rdata0} !== {2'b10, 32'd4}) $display("FAIL read_resp: rv=%b err=%b rdata=%h expected 1/0/00000004", rvalid0, err0, rdata0);
    else n_pass++;
  endtask

  task automatic test_contention();
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 4'h0; we1 = 4'h0; addr0 = 16'h0004; addr1 = 16'h0008;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL contention_%0d: gnt=%b%b", i, gnt0, gnt1);
      else n_pass++;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    n_checks++;
    if ({gcnt0, gcnt1} !== {16'd2, 16'd2}) $display("FAIL contention_cnt: gcnt=%0d/%0d expected 2/2", gcnt0, gcnt1);
    else n_pass++;
  endtask

  task automatic test_byte_write();
    req1 = 1'b1; we1 = 4'b0010; addr1 = 16'h0020; wdata1 = 32'h0000AB00;
    #1;
    n_checks++;
    if ({gnt1, web, addrb, dib} !== {1'b1, 4'b0010, 16'h0020, 32'h0000AB00}) $display("FAIL bw_port: gnt1=%b web=%b addrb=%h dib=%h", gnt1, web, addrb, dib);
    else n_pass++;
    tick();
    we1 = 4'h0;
    #1;
    n_checks++;
    if ({gnt1, rvalid1, rdata1} !== {2'b11, 32'h8}) $display("FAIL bw_write_resp: gnt1=%b rv=%b rdata=%h expected 1/1/00000008", gnt1, rvalid1, rdata1);
    else n_pass++;
    tick();
    req1 = 1'b0;
    #1;
    n_checks++;
    if ({rvalid1, rdata1} !== {1'b1, 32'h0000AB08}) $display("FAIL bw_read_resp: rv=%b rdata=%h expected 1/0000AB08", rvalid1, rdata1);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    req0 = 1'b1; we0 = 4'hF; addr0 = 16'h7FFC; wdata0 = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if ({gnt0, web} !== {1'b1, 4'hF}) $display("FAIL oor_edge_in: gnt0=%b web=%b expected 1/1111", gnt0, web);
    else n_pass++;
    tick();
    addr0 = 16'h8000; wdata0 = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({gnt0, web} !== {1'b1, 4'h0}) $display("FAIL oor_web: gnt0=%b web=%b expected 1/0000", gnt0, web);
    else n_pass++;
    tick();
    req0 = 1'b0; we0 = 4'h0;
    #1;
    n_checks++;
    if ({rvalid0, err0, rdata0} !== {2'b11, 32'd0}) $display("FAIL oor_resp: rv=%b err=%b rdata=%h expected 1/1/0", rvalid0, err0, rdata0);
    else n_pass++;
    n_checks++;
    if (bram[8192] !== 32'd8192) $display("FAIL oor_mem: word=%h expected 00002000", bram[8192]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    req1 = 1'b1; we1 = 4'hF; addr1 = 16'h0040; wdata1 = d;
    tick();
    req1 = 1'b0; we1 = 4'h0; req0 = 1'b1; we0 = 4'h0; addr0 = 16'h0042;
    #1;
    n_checks++;
    if ({gnt0, rvalid1, rdata1} !== {2'b11, 32'd16}) $display("FAIL b2b_first: gnt0=%b rv1=%b rdata1=%h expected 1/1/00000010", gnt0, rvalid1, rdata1);
    else n_pass++;
    tick();
    req0 = 1'b0;
    #1;
    n_checks++;
    if ({rvalid0, rdata0} !== {1'b1, d}) $display("FAIL b2b_raw: rv0=%b rdata0=%h expected 1/%h", rvalid0, rdata0, d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 4'h0; addr0 = 16'h0010;
    tick();
    rst = 1'b1; req0 = 1'b0;
    #1;
    n_checks++;
    if ({rvalid0, rdata0} !== 33'd0) $display("FAIL rstmid_drop: rv0=%b rdata0=%h expected 0/0", rvalid0, rdata0);
    else n_pass++;
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 4'h0; addr1 = 16'h0014;
    #1;
    n_checks++;
    if ({gnt0, gnt1, rvalid0} !== 3'b100) $display("FAIL rstmid_first: gnt=%b%b rv0=%b expected 10/0", gnt0, gnt1, rvalid0);
    else n_pass++;
    tick();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_random();
    int w, last_w;
    logic [15:0] a;
    logic [53:0] e_port;
    logic [33:0] e_r0, e_r1;
    last_w = -1;
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!req0 || last_w == 0) begin
        req0 = 1'($urandom_range(0, 1)); we0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        addr0 = rand_addr(); wdata0 = $urandom;
      end
      if (!req1 || last_w == 1) begin
        req1 = 1'($urandom_range(0, 1)); we1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        addr1 = rand_addr(); wdata1 = $urandom;
      end
      rst = ($urandom_range(0, 49) == 0);
      #1;
      w = winner();
      a = (w == 1) ? addr1 : addr0;
      e_port = (w < 0) ? 54'd0 : {w == 0, w == 1, (32'(a) < MEMB) ? ((w == 1) ? we1 : we0) : 4'h0, a, (w == 1) ? wdata1 : wdata0};
      e_r0 = (!rst && m_rv && m_ri == 0) ? {1'b1, m_re, m_rd} : 34'd0;
      e_r1 = (!rst && m_rv && m_ri == 1) ? {1'b1, m_re, m_rd} : 34'd0;
      n_checks++;
      if ({gnt0, gnt1, web, addrb, dib} !== e_port) $display("FAIL rand_port c%0d: got %h expected %h", c, {gnt0, gnt1, web, addrb, dib}, e_port);
      else n_pass++;
      n_checks++;
      if ({rvalid0, err0, rdata0} !== e_r0) $display("FAIL rand_rsp0 c%0d: got %h expected %h", c, {rvalid0, err0, rdata0}, e_r0);
      else n_pass++;
      n_checks++;
      if ({rvalid1, err1, rdata1} !== e_r1) $display("FAIL rand_rsp1 c%0d: got %h expected %h", c, {rvalid1, err1, rdata1}, e_r1);
      else n_pass++;
      n_checks++;
      if ({gcnt0, gcnt1} !== {16'(m_cnt[0]), 16'(m_cnt[1])}) $display("FAIL rand_cnt c%0d: got %0d/%0d expected %0d/%0d", c, gcnt0, gcnt1, m_cnt[0], m_cnt[1]);
      else n_pass++;
      last_w = w;
      tick();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b0; we0 = 4'h0; addr0 = 16'h0000;
    repeat (65534) tick();
    #1;
    n_checks++;
    if (gcnt0 !== 16'hFFFE) $display("FAIL sat_pre: gcnt0=%h expected FFFE", gcnt0);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      n_checks++;
      if (gcnt0 !== 16'hFFFF || !gnt0) $display("FAIL sat_%0d: gcnt0=%h gnt0=%b expected FFFF/1", i, gcnt0, gnt0);
      else n_pass++;
    end
    req0 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) m_mem[i] = i;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the byte-address width presented to the BRAM.
REQ-002 The block SHALL have parameter MEM_BYTES, default 32'h00008000, meaning the top of the mapped range; an access is in range when addr < MEM_BYTES.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each, access request from requester 0 (CPU data port) or requester 1 (loader).
REQ-006 The block SHALL have ports we0/we1, input, 4 bits each, byte write enables; 4'b0000 means read.
REQ-007 The block SHALL have ports addr0/addr1, input, ADDR_W bits each, byte address; bits [1:0] are ignored.
REQ-008 The block SHALL have ports wdata0/wdata1, input, 32 bits each, lane-aligned write data.
REQ-009 The block SHALL have ports gnt0/gnt1, output, 1 bit each, request accepted this cycle.
REQ-010 The block SHALL have ports rvalid0/rvalid1, output, 1 bit each, response valid.
REQ-011 The block SHALL have ports rdata0/rdata1, output, 32 bits each, read data.
REQ-012 The block SHALL have ports err0/err1, output, 1 bit each, out-of-range access flag, valid with rvalid.
REQ-013 The block SHALL have ports web (output, 4), addrb (output, ADDR_W), dib (output, 32) and dob (input, 32) connecting to the BRAM port, which has 1-cycle read-first latency.
REQ-014 The block SHALL have ports gcnt0/gcnt1, output, 16 bits each, saturating per-requester grant counters.

Function
REQ-015 Arbitration SHALL be combinational from req0/req1 and a registered last-grant pointer lg; exactly zero or one of gnt0/gnt1 is high per cycle.
REQ-016 If only one requester asserts req, that requester SHALL be granted in the same cycle.
REQ-017 If both requesters assert req, the requester not equal to lg SHALL be granted; lg SHALL update to the granted index on every grant and hold otherwise.
REQ-018 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; a request held continuously SHALL be granted within 2 cycles.
REQ-019 In the grant cycle, addrb SHALL equal the granted addr and dib the granted wdata; web SHALL equal the granted we when in range and 4'b0000 when out of range.
REQ-020 With no grant, web SHALL be 4'b0000, addrb 0 and dib 0.
REQ-021 Exactly one cycle after a grant, the granted requester's rvalid SHALL be high for one cycle, with rdata = dob for in-range accesses; writes also return rvalid, with rdata = pre-write word.
REQ-022 For an out-of-range access, the response SHALL carry err=1 and rdata=0; the BRAM SHALL not be written.
REQ-023 rdata and err SHALL be 0 whenever the corresponding rvalid is 0.
REQ-024 Back-to-back grants SHALL be allowed every cycle (full throughput); a read granted the cycle after a write to the same word SHALL return the written data.
REQ-025 gcntN SHALL increment by one on each gntN and saturate at 16'hFFFF.

Reset
REQ-026 While rst is high: gnt0/gnt1=0, web=0, addrb=0, dib=0, and no BRAM write SHALL occur.
REQ-027 On the edge where rst is sampled high: rvalid0/1=0, rdata0/1=0, err0/1=0, gcnt0/1=0 and lg=1, so requester 0 wins the first contention; a response for a grant issued in the cycle before reset SHALL be discarded.

Verification
REQ-028 Single read: req0, addr0=16'h0010, we0=0 -> gnt0 same cycle, addrb=16'h0010; next cycle rvalid0=1 with rdata0 equal to the stored word 4.
REQ-029 Contention: req0 and req1 held high for 4 cycles from reset -> grant order 0,1,0,1; gcnt0=2 and gcnt1=2.
REQ-030 Byte write then read: req1 we1=4'b0010, addr1=16'h0020, wdata1=32'h0000AB00, then read of 16'h0020 next cycle -> rdata1=32'h0000AB08.
REQ-031 Out of range: req0 addr0=16'h8000, we0=4'hF -> web=0; next cycle rvalid0=1, err0=1, rdata0=0; memory unchanged.
REQ-032 Reset mid-operation: grant req0 read at cycle N, rst=1 at cycle N+1 -> rvalid0 stays 0; after release, contention grants requester 0 first.
REQ-033 Saturation: force gcnt0 to 16'hFFFE and grant twice -> gcnt0=16'hFFFF and it holds.
